mem_arbiter: RTL and testbench

- Shares one multi-cycle, pipelined unified main memory between the I-cache miss path (IF stage) and the D-cache miss path and write-through store path (MEM stage).
- Sequences 8-word block refills and single-word stores.
- Steers returned words back to the requesting cache with a word index.
- While a requester is unserved, the pipeline stays stalled by that requester's own miss signal; this block only grants, sequences and acknowledges.

---
 rtl/mem_arbiter_pkg.sv | 20 ++
 rtl/block_word_counter.sv | 34 +++
 rtl/mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter slice.
//   - FSM state encoding
//   - block geometry: words per block, byte-offset bits within a block
//   - word-index and counter widths
package mem_arbiter_pkg;

    localparam int unsigned WORDS_PER_BLOCK   = 8;
    localparam int unsigned BLOCK_OFFSET_BITS = 4;  // 16-byte blocks
    localparam int unsigned WORD_IDX_W        = 3;
    localparam int unsigned CNT_W             = 4;  // must be able to hold WORDS_PER_BLOCK

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StWrite = 3'd1,
        StFillI = 3'd2,
        StFillD = 3'd3,
        StGap   = 3'd4
    } arb_state_e;

endpackage

// File: rtl/block_word_counter.sv
// Word counter for a block transfer.
//   clk   : system clock
//   rst   : synchronous active-high reset
//   clr   : synchronous clear
//   inc   : advance by one (ignored once the terminal count is reached)
//   idx   : low bits of the count, i.e. the word index within the block
//   term  : count has reached Terminal (all words done)
module block_word_counter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned Terminal = WORDS_PER_BLOCK
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  inc,
    output logic [WORD_IDX_W-1:0] idx,
    output logic                  term
);

    logic [CNT_W-1:0] cnt_q;

    assign term = (cnt_q == CNT_W'(Terminal));
    assign idx  = cnt_q[WORD_IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (inc && !term) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one pipelined main memory between the I-cache miss path and
// the D-cache miss / write-through store path.
//   clk, rst          : clock, synchronous active-high reset
//   i_miss_req/addr   : I-cache block miss (level, held until i_fill_done)
//   d_miss_req/addr   : D-cache block miss (level, held until d_fill_done)
//   d_wr_req/addr/data: write-through store (level, held until d_wr_ack)
//   mem_*             : memory access port; reads return on mem_rvalid
//   fill_*            : refill word steering back to the caches
//   *_done, d_wr_ack  : one-cycle completion pulses
//   busy              : FSM not idle
// Priority in idle: store > D miss > I miss. A one-cycle gap follows every
// operation so the served requester can drop its level request.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_miss_req,
    input  logic [ADDR_W-1:0]     i_miss_addr,
    input  logic                  d_miss_req,
    input  logic [ADDR_W-1:0]     d_miss_addr,
    input  logic                  d_wr_req,
    input  logic [ADDR_W-1:0]     d_wr_addr,
    input  logic [DATA_W-1:0]     d_wr_data,
    output logic                  mem_en,
    output logic                  mem_wr,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_rvalid,
    output logic [DATA_W-1:0]     fill_data,
    output logic [WORD_IDX_W-1:0] fill_word,
    output logic                  i_fill_we,
    output logic                  d_fill_we,
    output logic                  i_fill_done,
    output logic                  d_fill_done,
    output logic                  d_wr_ack,
    output logic                  busy
);

    arb_state_e state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic                  in_fill;
    logic                  cnt_clr;
    logic                  issue_inc, recv_inc;
    logic                  issue_term, recv_term;
    logic [WORD_IDX_W-1:0] issue_idx, recv_idx;
    logic                  last_word;
    logic [ADDR_W-1:0]     block_base;

    assign in_fill    = (state_q == StFillI) || (state_q == StFillD);
    assign cnt_clr    = (state_q == StGap);
    assign issue_inc  = in_fill && !issue_term;
    // Returns outside a fill, or beyond the 8th word, are dropped here.
    assign recv_inc   = in_fill && mem_rvalid && !recv_term;
    assign last_word  = recv_inc && (recv_idx == WORD_IDX_W'(WORDS_PER_BLOCK - 1));
    assign block_base = {addr_q[ADDR_W-1:BLOCK_OFFSET_BITS], {BLOCK_OFFSET_BITS{1'b0}}};

    block_word_counter #(
        .Terminal (WORDS_PER_BLOCK)
    ) u_issue_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (issue_inc),
        .idx  (issue_idx),
        .term (issue_term)
    );

    block_word_counter #(
        .Terminal (WORDS_PER_BLOCK)
    ) u_recv_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (recv_inc),
        .idx  (recv_idx),
        .term (recv_term)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        fill_data   = '0;
        fill_word   = '0;
        i_fill_we   = 1'b0;
        d_fill_we   = 1'b0;
        i_fill_done = 1'b0;
        d_fill_done = 1'b0;
        d_wr_ack    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (d_wr_req) begin
                    state_d = StWrite;
                    addr_d  = d_wr_addr;
                    wdata_d = d_wr_data;
                end else if (d_miss_req) begin
                    state_d = StFillD;
                    addr_d  = d_miss_addr;
                end else if (i_miss_req) begin
                    state_d = StFillI;
                    addr_d  = i_miss_addr;
                end
            end

            StWrite: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                d_wr_ack  = 1'b1;
                state_d   = StGap;
            end

            StFillI, StFillD: begin
                if (issue_inc) begin
                    mem_en   = 1'b1;
                    // Aligned base plus at most 14: never carries past the block.
                    mem_addr = block_base + ADDR_W'({issue_idx, 1'b0});
                end
                if (recv_inc) begin
                    fill_data = mem_rdata;
                    fill_word = recv_idx;
                    if (state_q == StFillI) begin
                        i_fill_we = 1'b1;
                    end else begin
                        d_fill_we = 1'b1;
                    end
                end
                if (last_word) begin
                    if (state_q == StFillI) begin
                        i_fill_done = 1'b1;
                    end else begin
                        d_fill_done = 1'b1;
                    end
                    state_d = StGap;
                end
            end

            StGap: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int L = 4;  // memory read latency in cycles

    typedef logic [58:0] obs_t;

    typedef struct {
        logic        rst;
        logic        wr_req;
        logic [15:0] wr_addr;
        logic [15:0] wr_data;
        logic        d_miss;
        logic [15:0] d_addr;
        logic        i_miss;
        logic [15:0] i_addr;
        logic        xrv;
        obs_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_miss_req, d_miss_req, d_wr_req;
    logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
    logic        mem_en, mem_wr, mem_rvalid;
    logic [15:0] mem_addr, mem_wdata, mem_rdata, fill_data;
    logic [2:0]  fill_word;
    logic        i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_ack, busy;
    logic        extra_rv;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .i_miss_req  (i_miss_req),
        .i_miss_addr (i_miss_addr),
        .d_miss_req  (d_miss_req),
        .d_miss_addr (d_miss_addr),
        .d_wr_req    (d_wr_req),
        .d_wr_addr   (d_wr_addr),
        .d_wr_data   (d_wr_data),
        .mem_en      (mem_en),
        .mem_wr      (mem_wr),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_rvalid  (mem_rvalid),
        .fill_data   (fill_data),
        .fill_word   (fill_word),
        .i_fill_we   (i_fill_we),
        .d_fill_we   (d_fill_we),
        .i_fill_done (i_fill_done),
        .d_fill_done (d_fill_done),
        .d_wr_ack    (d_wr_ack),
        .busy        (busy)
    );

    // Fixed-latency memory: read data is address ^ 0xA5A5. Not reset, so reads
    // in flight across a DUT reset still come back.
    logic [L-1:0] rv_pipe = '0;
    logic [15:0]  d_pipe [L];

    always @(posedge clk) begin
        rv_pipe   <= {rv_pipe[L-2:0], mem_en && !mem_wr};
        d_pipe[0] <= mem_addr ^ 16'hA5A5;
        for (int i = 1; i < L; i++) d_pipe[i] <= d_pipe[i-1];
    end

    assign mem_rvalid = rv_pipe[L-1] | extra_rv;
    assign mem_rdata  = rv_pipe[L-1] ? d_pipe[L-1] : 16'hDEAD;

    function automatic obs_t mk(input logic en, input logic wr, input logic [15:0] addr,
                                input logic [15:0] wdata, input logic [15:0] fdata,
                                input logic [2:0] fword, input logic ifwe, input logic dfwe,
                                input logic idone, input logic ddone, input logic ack,
                                input logic bsy);
        return {en, wr, addr, wdata, fdata, fword, ifwe, dfwe, idone, ddone, ack, bsy};
    endfunction

    localparam obs_t ZERO = '0;
    localparam obs_t ONLY_BUSY = 59'd1;

    // Expected outputs k cycles after a fill request is first seen in idle
    // (k=0 idle, 1..8 issue, 5..12 receive with L=4, 13 gap).
    function automatic obs_t exp_fill(input bit is_d, input logic [15:0] base, input int k);
        logic        en, we, done, bsy;
        logic [15:0] a, fd;
        logic [2:0]  w;
        en = 1'b0; we = 1'b0; done = 1'b0; bsy = 1'b0;
        a = '0; fd = '0; w = '0;
        if (k >= 1) bsy = 1'b1;
        if (k >= 1 && k <= 8) begin
            en = 1'b1;
            a  = base + 16'(2 * (k - 1));
        end
        if (k >= 1 + L && k <= 8 + L) begin
            we = 1'b1;
            w  = 3'(k - 1 - L);
            fd = (base + 16'(2 * (k - 1 - L))) ^ 16'hA5A5;
        end
        done = (k == 8 + L);
        return mk(en, 1'b0, a, 16'h0, fd, w, we && !is_d, we && is_d,
                  done && !is_d, done && is_d, 1'b0, bsy);
    endfunction

    task automatic chk(input string name, input obs_t exp);
        obs_t act;
        act = mk(mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word, i_fill_we,
                 d_fill_we, i_fill_done, d_fill_done, d_wr_ack, busy);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (en,wr,addr,wdata,fdata,fword,ifwe,dfwe,idone,ddone,ack,busy)",
                     name, act, exp);
        end
    endtask

    // Inputs are set just after a rising edge; outputs are sampled on the falling edge.
    task automatic cyc(input string name, input obs_t exp);
        @(negedge clk);
        chk(name, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic fill_seq(input bit is_d, input logic [15:0] base, input bit hold);
        for (int k = 0; k <= 9 + L; k++) begin
            if (k == 9 + L) begin
                extra_rv = 1'b1;  // stray return after the 8th word
                if (!hold) begin
                    if (is_d) d_miss_req = 1'b0;
                    else      i_miss_req = 1'b0;
                end
            end
            cyc($sformatf("fill_%s_%h_k%0d", is_d ? "d" : "i", base, k), exp_fill(is_d, base, k));
        end
        extra_rv = 1'b0;
    endtask

    vec_t vecs [11];

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 16'h0,    16'h0,    1'b0, 16'h0,    1'b0, 16'h0,    1'b0, ZERO};
        vecs[1]  = '{1'b0, 1'b1, 16'h2002, 16'hBEEF, 1'b0, 16'h0,    1'b0, 16'h0,    1'b0, ZERO};
        vecs[2]  = '{1'b0, 1'b1, 16'h2002, 16'hBEEF, 1'b0, 16'h0,    1'b0, 16'h0,    1'b0,
                     mk(1'b1, 1'b1, 16'h2002, 16'hBEEF, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                        1'b1, 1'b1)};
        vecs[3]  = '{1'b0, 1'b0, 16'h0,    16'h0,    1'b0, 16'h0,    1'b0, 16'h0,    1'b0, ONLY_BUSY};
        vecs[4]  = '{1'b0, 1'b0, 16'h0,    16'h0,    1'b0, 16'h0,    1'b0, 16'h0,    1'b1, ZERO};
        vecs[5]  = '{1'b0, 1'b1, 16'h0004, 16'h1234, 1'b1, 16'h4000, 1'b0, 16'h0,    1'b0, ZERO};
        vecs[6]  = '{1'b0, 1'b1, 16'h0004, 16'h1234, 1'b1, 16'h4000, 1'b0, 16'h0,    1'b0,
                     mk(1'b1, 1'b1, 16'h0004, 16'h1234, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                        1'b1, 1'b1)};
        vecs[7]  = '{1'b0, 1'b0, 16'h0,    16'h0,    1'b0, 16'h0,    1'b0, 16'h0,    1'b0, ONLY_BUSY};
        vecs[8]  = '{1'b0, 1'b0, 16'h0,    16'h0,    1'b0, 16'h0,    1'b0, 16'h0,    1'b0, ZERO};
        vecs[9]  = '{1'b1, 1'b0, 16'h0,    16'h0,    1'b0, 16'h0,    1'b1, 16'h0100, 1'b0, ZERO};
        vecs[10] = '{1'b0, 1'b0, 16'h0,    16'h0,    1'b0, 16'h0,    1'b0, 16'h0,    1'b0, ZERO};

        rst = 1'b1;
        i_miss_req = 1'b0; d_miss_req = 1'b0; d_wr_req = 1'b0;
        i_miss_addr = '0; d_miss_addr = '0; d_wr_addr = '0; d_wr_data = '0;
        extra_rv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("reset_state", ZERO);

        // Stores, priority over a D miss, idle stray rvalid, reset blocking a grant.
        for (int i = 0; i < 11; i++) begin
            rst         = vecs[i].rst;
            d_wr_req    = vecs[i].wr_req;
            d_wr_addr   = vecs[i].wr_addr;
            d_wr_data   = vecs[i].wr_data;
            d_miss_req  = vecs[i].d_miss;
            d_miss_addr = vecs[i].d_addr;
            i_miss_req  = vecs[i].i_miss;
            i_miss_addr = vecs[i].i_addr;
            extra_rv    = vecs[i].xrv;
            cyc($sformatf("vec%0d", i), vecs[i].exp);
        end
        rst = 1'b0; d_wr_req = 1'b0; d_miss_req = 1'b0; i_miss_req = 1'b0; extra_rv = 1'b0;

        // Plain I refill from an unaligned address.
        i_miss_req = 1'b1; i_miss_addr = 16'h0126;
        fill_seq(1'b0, 16'h0120, 1'b0);
        cyc("i_fill_idle_after", ZERO);

        // Simultaneous D and I misses: D first, then I after the gap.
        d_miss_req = 1'b1; d_miss_addr = 16'h4000;
        i_miss_req = 1'b1; i_miss_addr = 16'h0010;
        fill_seq(1'b1, 16'h4000, 1'b0);
        fill_seq(1'b0, 16'h0010, 1'b0);
        cyc("di_idle_after", ZERO);

        // Reset after three D words; the remaining returns must be ignored.
        d_miss_req = 1'b1; d_miss_addr = 16'h300A;
        for (int k = 0; k < 3 + L; k++) cyc($sformatf("rst_fill_k%0d", k), exp_fill(1'b1, 16'h3000, k));
        rst = 1'b1;
        cyc("rst_fill_word2", exp_fill(1'b1, 16'h3000, 3 + L));
        rst = 1'b0; d_miss_req = 1'b0;
        for (int j = 0; j < L; j++) cyc($sformatf("rst_flush%0d", j), ZERO);
        i_miss_req = 1'b1; i_miss_addr = 16'h0056;
        fill_seq(1'b0, 16'h0050, 1'b0);
        cyc("post_rst_idle", ZERO);

        // Request held through the gap: no re-grant.
        i_miss_req = 1'b1; i_miss_addr = 16'h0F08;
        fill_seq(1'b0, 16'h0F00, 1'b1);
        i_miss_req = 1'b0;
        cyc("hold_idle0", ZERO);
        cyc("hold_idle1", ZERO);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
